// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   step_scratch;
  logic            step_ovf;
  logic            last_iter;

  assign last_iter = (state_q == S_SHIFT) && (cnt_q == CW'(BIN_W - 1));

  // One double-dabble step: per-digit add-3, then shift in the next binary bit.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    step_scratch = {adj[BW-2:0], shift_q[BIN_W-1]};
    step_ovf     = ovf_q | adj[BW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_SHIFT;
      S_SHIFT: if (last_iter) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT);
  end

  always_comb begin
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = last_iter;
    if (state_q == S_IDLE) begin
      if (start) begin
        shift_d   = bin;
        scratch_d = '0;
        ovf_d     = 1'b0;
        cnt_d     = '0;
      end
    end else begin
      shift_d   = shift_q << 1;
      scratch_d = step_scratch;
      ovf_d     = step_ovf;
      cnt_d     = cnt_q + CW'(1);
    end
    if (last_iter) begin
      bcd_d      = step_ovf ? {DIGITS{4'h9}} : step_scratch;
      overflow_d = step_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_n;
  logic              zero_above;

  // Scan from the top digit down; units digit is never blanked.
  always_comb begin
    blank_n    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (step_scratch[4*i +: 4] == 4'd0);
      blank_n[i] = zero_above && !step_ovf;
    end
    blank_d = last_iter ? blank_n : blank_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq (5-digit and 4-digit instances).
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;

  logic        busy5, done5, ovf5;
  logic [19:0] bcd5;
  logic [4:0]  blank5;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;
  logic [3:0]  blank4;

  int tests = 0;
  int fails = 0;
  int lat;
  int ndone;

`ifdef BIN2BCD_BLANK_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy5), .done(done5), .bcd(bcd5), .overflow(ovf5), .blank(blank5)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4), .blank(blank4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] blk(input logic [4:0] m);
    return BE ? m : 5'b0;
  endfunction

  // Drive start for one edge, then count edges until done (bounded).
  task automatic run(input logic [15:0] v, output int l);
    bin   = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 1;
    while (!done5 && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    chk("done_seen", {31'b0, done5}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert (!(busy5 && done5)) else begin
        fails++;
        $error("FAIL busy_done_overlap: observed busy=%b done=%b expected not both", busy5, done5);
      end
    end
  end

  initial begin
    #1;
    chk("rst_busy", {31'b0, busy5}, 32'd0);
    chk("rst_done", {31'b0, done5}, 32'd0);
    chk("rst_bcd", {12'b0, bcd5}, 32'h0);
    chk("rst_ovf", {31'b0, ovf5}, 32'd0);
    chk("rst_blank", {27'b0, blank5}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(16'd0, lat);
    chk("zero_lat", lat, 32'd17);
    chk("zero_bcd", {12'b0, bcd5}, 32'h00000);
    chk("zero_ovf", {31'b0, ovf5}, 32'd0);
    chk("zero_blank", {27'b0, blank5}, {27'b0, blk(5'b11110)});
    chk("zero_busy", {31'b0, busy5}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done5}, 32'd0);

    run(16'd65535, lat);
    chk("max_lat", lat, 32'd17);
    chk("max_bcd", {12'b0, bcd5}, 32'h65535);
    chk("max_ovf", {31'b0, ovf5}, 32'd0);
    chk("max_blank", {27'b0, blank5}, 32'd0);
    chk("max4_bcd", {16'b0, bcd4}, 32'h9999);
    chk("max4_ovf", {31'b0, ovf4}, 32'd1);
    run(16'd12345, lat);
    chk("b2b_lat", lat, 32'd17);
    chk("b2b_bcd", {12'b0, bcd5}, 32'h12345);
    chk("b2b_ovf", {31'b0, ovf5}, 32'd0);

    @(posedge clk); #1;
    run(16'd10000, lat);
    chk("ovf4_bcd", {16'b0, bcd4}, 32'h9999);
    chk("ovf4_ovf", {31'b0, ovf4}, 32'd1);
    chk("ovf4_done", {31'b0, done4}, 32'd1);
    chk("ovf4_blank", {28'b0, blank4}, 32'd0);
    chk("ovf5_bcd", {12'b0, bcd5}, 32'h10000);
    run(16'd9999, lat);
    chk("fit4_bcd", {16'b0, bcd4}, 32'h9999);
    chk("fit4_ovf", {31'b0, ovf4}, 32'd0);
    chk("fit5_bcd", {12'b0, bcd5}, 32'h09999);
    chk("fit5_blank", {27'b0, blank5}, {27'b0, blk(5'b10000)});

    @(posedge clk); #1;
    bin   = 16'd1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy5}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    bin   = 16'd999;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 16'd777;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done5) ndone++;
    end
    chk("busy_single_done", ndone, 32'd1);
    chk("busy_bcd", {12'b0, bcd5}, 32'h01234);
    chk("busy_blank", {27'b0, blank5}, {27'b0, blk(5'b10000)});

    bin   = 16'd65535;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy5}, 32'd0);
    chk("mid_rst_bcd", {12'b0, bcd5}, 32'h0);
    chk("mid_rst_bcd4", {16'b0, bcd4}, 32'h0);
    chk("mid_rst_ovf", {31'b0, ovf5}, 32'd0);
    ndone = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done5) ndone++;
    end
    chk("mid_rst_no_done", ndone, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(16'd4321, lat);
    chk("post_rst_lat", lat, 32'd17);
    chk("post_rst_bcd", {12'b0, bcd5}, 32'h04321);

    run(16'd42, lat);
    chk("blank42_bcd", {12'b0, bcd5}, 32'h00042);
    chk("blank42_blank", {27'b0, blank5}, {27'b0, blk(5'b11100)});
    chk("blank42_ovf", {31'b0, ovf5}, 32'd0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
